crypto_mul_arbiter: RTL and testbench
=====================================

# crypto_mul_arbiter

Round-robin arbiter that shares one combinational 15-bit x 16-bit unsigned multiplier (31-bit product) among `N_REQ` requesters in the Crypto datapath. It selects one requester per cycle, drives the multiplier operand ports, and captures the product together with the requester ID in an output register. The output register provides a valid/ready response stream with backpressure. The block sits between the modular-arithmetic lanes and the single shared multiplier instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester ID, equal to clog2(`N_REQ`).
- `ap_clk` in 1: the single clock; all state updates on the rising edge.
- `ap_rst` in 1: reset, asynchronous and active-high.
- `req_valid` in `N_REQ`: request valid, one bit per requester.
- `req_a` in `N_REQ`*15: operand A, packed; requester i occupies bits [15i+14:15i].
- `req_b` in `N_REQ`*16: operand B, packed; requester i occupies bits [16i+15:16i].
- `req_ready` out `N_REQ`: request accepted this cycle (combinational).
- `req_en` in `N_REQ`: enable mask. A requester whose bit is 0 is never granted.
- `mul_din0` out 15: multiplier operand A.
- `mul_din1` out 16: multiplier operand B.
- `mul_dout` in 31: multiplier product, combinational from `mul_din0`/`mul_din1`.
- `rsp_valid` out 1: response valid (registered).
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_data` out 31: product (registered).
- `rsp_id` out `ID_W`: index of the requester that produced the response (registered).
- `issue_cnt` out 16: count of accepted requests; wraps modulo 2^16.

## Operation
- Eligibility: `elig = req_valid & req_en`.
- Capacity: `can_accept = !rsp_valid | rsp_ready`.
- Grant (combinational): the first set bit of `elig`, searching upward from `rr_ptr+1` modulo `N_REQ`. If `elig` is 0, there is no grant.
- `req_ready[i] = grant[i] & can_accept`. At most one bit of `req_ready` is ever set.
- `mul_din0`/`mul_din1` carry the granted requester's operands, or 0 when there is no grant. Operands are driven regardless of `can_accept`.
- Accept event: any bit of `req_ready` is set. On that edge:
  - `rsp_data <= mul_dout`, `rsp_id <= granted index`, `rsp_valid <= 1`.
  - `rr_ptr <= granted index`.
  - `issue_cnt` increments by 1.
- Drain without accept (`rsp_valid & rsp_ready` and no accept): `rsp_valid <= 0`. `rsp_data`/`rsp_id` hold their last values.
- Stall (`rsp_valid & !rsp_ready`): all `req_ready` are 0, the response registers hold, and `rr_ptr` holds.
- Requesters hold `req_valid` and their operands stable until `req_ready` is seen. Dropping `req_valid` before acceptance is legal; that requester is simply no longer eligible.
- Arithmetic: unsigned, zero-extended. The 31-bit product of 15x16 operands is exact and has no overflow. The block checks that `mul_dout` width is 31 and does not recompute the product.
- `rr_ptr` changes only on an accept, never on idle cycles or `req_en` changes.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `issue_cnt`=0, `rr_ptr`=`N_REQ`-1 (so requester 0 has first priority).
- Asynchronous reset assertion mid-operation discards any held response immediately. `req_ready` is 0 while `ap_rst` is 1.
- Latency: a request accepted at edge k produces `rsp_valid`=1 with its data in the cycle after edge k.
- Throughput: one accept per cycle while `rsp_ready`=1. The simultaneous drain-and-accept edge keeps `rsp_valid`=1 with the new data.
- Fairness: with all requesters continuously eligible and no stall, grants rotate 0,1,2,3,0,…. Any eligible requester waits at most `N_REQ`-1 accepts.
- `issue_cnt` wrap: 0xFFFF followed by an accept gives 0x0000.

## Test plan
- Reset and single request: reset, then requester 2 presents a=0x7FFF, b=0xFFFF with `rsp_ready`=1. Required: `req_ready`[2] is high in the same cycle; the next cycle shows `rsp_valid`=1, `rsp_data`=0x7FFE8001, `rsp_id`=2, `issue_cnt`=1.
- Round-robin: all 4 requesters valid, `req_en`=0xF, `rsp_ready`=1 for 8 cycles. Required: `rsp_id` sequence 0,1,2,3,0,1,2,3; `issue_cnt`=8.
- Backpressure: while a response is held, drop `rsp_ready` for 3 cycles with requesters 1 and 3 valid. Required: `req_ready`=0 for all 3 cycles; `rsp_data`/`rsp_id` stable; `rr_ptr` unchanged. When `rsp_ready` rises, the next grant follows the rotation order.
- Enable mask: `req_en`=0b1010 with all 4 requesters valid. Required: only IDs 1 and 3 alternate; requesters 0 and 2 never see `req_ready`.
- Reset mid-stream: assert `ap_rst` asynchronously between edges while `rsp_valid`=1. Required: `rsp_valid`, `rsp_data` and `issue_cnt` read 0 immediately. After release, requester 0 is granted first.
- Counter wrap and idle: preload the count to 0xFFFF via 65535 accepts, then issue 1 more. Required: `issue_cnt`=0. With `elig`=0, `mul_din0`=`mul_din1`=0 and `rsp_valid` drains to 0.

Source files
------------

// File: rtl/crypto_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 15x16 multiplier among N_REQ
// requesters; the product and requester ID go out on a registered valid/ready stream.
module crypto_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*15-1:0] req_a,
  input  logic [N_REQ*16-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_en,
  output logic [14:0]         mul_din0,
  output logic [15:0]         mul_din1,
  input  logic [30:0]         mul_dout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [30:0]         rsp_data,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         issue_cnt,
  output logic [ID_W-1:0]     dbg_rr_ptr
);

  // Handshake: a request moves on an edge where req_valid[i] and req_ready[i]
  // are both high; a response moves on an edge where rsp_valid and rsp_ready
  // are both high. req_ready never depends on req_ready of another requester.

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_rsp_valid;
  logic [30:0]      r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic [15:0]      r_issue_cnt;

  logic [N_REQ-1:0] w_elig;
  logic             w_can_accept;
  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_idx;
  logic [N_REQ-1:0] w_grant_oh;
  logic             w_accept;

  assign w_elig       = req_valid & req_en;
  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // Search starts just past the last winner, wrapping modulo N_REQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_grant_vld && w_elig[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  assign req_ready  = (w_can_accept && !ap_rst) ? w_grant_oh : '0;
  assign w_accept   = |req_ready;

  // Operands follow the grant even when stalled so the multiplier output settles early.
  assign mul_din0 = w_grant_vld ? req_a[int'(w_grant_idx)*15 +: 15] : '0;
  assign mul_din1 = w_grant_vld ? req_b[int'(w_grant_idx)*16 +: 16] : '0;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_rr_ptr    <= ID_W'(N_REQ-1);
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_issue_cnt <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= mul_dout;
      r_rsp_id    <= w_grant_idx;
      r_rr_ptr    <= w_grant_idx;
      r_issue_cnt <= r_issue_cnt + 16'd1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign issue_cnt  = r_issue_cnt;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_crypto_mul_arbiter.sv
// Directed bench for crypto_mul_arbiter with a behavioural multiplier and
// hand-derived expected grants, responses and counts.
module tb_crypto_mul_arbiter;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [59:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  req_en;
  logic [14:0] mul_din0;
  logic [15:0] mul_din1;
  logic [30:0] mul_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [30:0] rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] issue_cnt;
  logic [1:0]  dbg_rr_ptr;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] op_a [4];
  logic [15:0] op_b [4];
  logic [1:0]  exp_q [$];
  logic [30:0] exp_data_q [$];
  logic [30:0] held_data;
  logic [1:0]  exp_id;

  crypto_mul_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .req_en     (req_en),
    .mul_din0   (mul_din0),
    .mul_din1   (mul_din1),
    .mul_dout   (mul_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .issue_cnt  (issue_cnt),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Shared multiplier instance outside the arbiter
  assign mul_dout = {16'd0, mul_din0} * {15'd0, mul_din1};

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[15*i +: 15] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
    end
  endtask

  function automatic logic [30:0] prod(input int i);
    return {16'd0, op_a[i]} * {15'd0, op_b[i]};
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_en    = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 15'h0100 + 15'(i * 7);
      op_b[i] = 16'h0200 + 16'(i * 13);
    end
    step();
    step();
    ap_rst = 1'b0;

    // reset state
    check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_data",  {1'b0, rsp_data}, 32'd0);
    check_eq("rst_id",    {30'd0, rsp_id}, 32'd0);
    check_eq("rst_cnt",   {16'd0, issue_cnt}, 32'd0);
    check_eq("rst_ptr",   {30'd0, dbg_rr_ptr}, 32'd3);

    // single request, max operands on requester 2
    req_a[44:30] = 15'h7FFF;
    req_b[47:32] = 16'hFFFF;
    req_valid    = 4'b0100;
    #1;
    check_eq("single_ready", {28'd0, req_ready}, 32'h4);
    check_eq("single_din0",  {17'd0, mul_din0}, 32'h7FFF);
    step();
    req_valid = '0;
    check_eq("single_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("single_data",  {1'b0, rsp_data}, 32'h7FFE8001);
    check_eq("single_id",    {30'd0, rsp_id}, 32'd2);
    check_eq("single_cnt",   {16'd0, issue_cnt}, 32'd1);

    // round robin with all four requesters
    do_reset();
    load_ops();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      exp_id = 2'(c % 4);
      exp_q.push_back(exp_id);
      exp_data_q.push_back(prod(c % 4));
      #1;
      check_eq("rr_ready", {28'd0, req_ready}, 32'(1) << exp_id);
      step();
      check_eq("rr_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("rr_id",    {30'd0, rsp_id}, {30'd0, exp_q.pop_front()});
      check_eq("rr_data",  {1'b0, rsp_data}, {1'b0, exp_data_q.pop_front()});
    end
    check_eq("rr_cnt", {16'd0, issue_cnt}, 32'd8);

    // backpressure: response for requester 3 held, 1 and 3 pending
    held_data = prod(3);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_ready", {28'd0, req_ready}, 32'd0);
      check_eq("bp_id",    {30'd0, rsp_id}, 32'd3);
      check_eq("bp_data",  {1'b0, rsp_data}, {1'b0, held_data});
      check_eq("bp_ptr",   {30'd0, dbg_rr_ptr}, 32'd3);
      check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_resume_ready", {28'd0, req_ready}, 32'h2);
    step();
    check_eq("bp_resume_id",   {30'd0, rsp_id}, 32'd1);
    check_eq("bp_resume_data", {1'b0, rsp_data}, {1'b0, prod(1)});

    // enable mask: only 1 and 3 may win
    req_en    = 4'b1010;
    req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      exp_id = (c % 2 == 0) ? 2'd3 : 2'd1;
      exp_q.push_back(exp_id);
      #1;
      check_eq("mask_ready", {28'd0, req_ready}, 32'(1) << exp_id);
      step();
      check_eq("mask_id", {30'd0, rsp_id}, {30'd0, exp_q.pop_front()});
    end
    req_en = 4'hF;

    // asynchronous reset while a response is held
    check_eq("mid_pre_valid", {31'd0, rsp_valid}, 32'd1);
    #2 ap_rst = 1'b1;
    #1;
    check_eq("mid_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_data",  {1'b0, rsp_data}, 32'd0);
    check_eq("mid_cnt",   {16'd0, issue_cnt}, 32'd0);
    check_eq("mid_ready", {28'd0, req_ready}, 32'd0);
    step();
    ap_rst = 1'b0;
    #1;
    check_eq("mid_first_ready", {28'd0, req_ready}, 32'h1);
    step();
    check_eq("mid_first_id", {30'd0, rsp_id}, 32'd0);
    req_valid = '0;

    // counter wrap, then idle drain
    do_reset();
    req_valid = 4'b0001;
    repeat (65535) @(posedge ap_clk);
    #1;
    check_eq("wrap_ffff", {16'd0, issue_cnt}, 32'hFFFF);
    step();
    check_eq("wrap_zero", {16'd0, issue_cnt}, 32'd0);
    req_valid = '0;
    #1;
    check_eq("idle_din0",  {17'd0, mul_din0}, 32'd0);
    check_eq("idle_din1",  {16'd0, mul_din1}, 32'd0);
    check_eq("idle_ready", {28'd0, req_ready}, 32'd0);
    step();
    check_eq("idle_drain", {31'd0, rsp_valid}, 32'd0);
    check_eq("idle_cnt",   {16'd0, issue_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
